// File: rtl/dmem_ctrl_if.sv
// Signal bundle between the MEM stage, the data-memory controller and the data bus.
// The controller is the bus master; the slave view is the surrounding
// pipeline/bus side.
interface dmem_ctrl_if;
   // MEM stage request and response
   logic        mem_ce_i;
   logic        mem_we_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_data_i;
   logic [3:0]  mem_sel_i;
   logic [31:0] mem_data_o;
   logic        stall_req_o;
   // data bus
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_wdata_o;
   logic [3:0]  bus_sel_o;
   logic        bus_ack_i;
   logic [31:0] bus_rdata_i;
   logic        bus_err_o;

   modport master (
      input  mem_ce_i, mem_we_i, mem_addr_i, mem_data_i, mem_sel_i,
      input  bus_ack_i, bus_rdata_i,
      output mem_data_o, stall_req_o,
      output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o, bus_err_o
   );

   modport slave (
      output mem_ce_i, mem_we_i, mem_addr_i, mem_data_i, mem_sel_i,
      output bus_ack_i, bus_rdata_i,
      input  mem_data_o, stall_req_o,
      input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o, bus_err_o
   );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns one MEM-stage request into a
// req/ack bus transaction, stalls the pipeline while it is outstanding and
// hands the full read word back in the DONE cycle.
module dmem_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   dmem_ctrl_if.master dmem
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t             state_reg, state_next;
   logic               req_reg, req_next;
   logic               we_reg, we_next;
   logic [31:0]        addr_reg, addr_next;
   logic [31:0]        wdata_reg, wdata_next;
   logic [3:0]         sel_reg, sel_next;
   logic [31:0]        rdata_reg, rdata_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               err_reg, err_next;

   // The last waiting cycle is the one where the counter still reads TIMEOUT-1;
   // leaving at that edge gives exactly TIMEOUT cycles in REQ.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   // State and datapath registers, all cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         req_reg   <= 1'b0;
         we_reg    <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         sel_reg   <= '0;
         rdata_reg <= '0;
         cnt_reg   <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         req_reg   <= req_next;
         we_reg    <= we_next;
         addr_reg  <= addr_next;
         wdata_reg <= wdata_next;
         sel_reg   <= sel_next;
         rdata_reg <= rdata_next;
         cnt_reg   <= cnt_next;
         err_reg   <= err_next;
      end
   end

   // Next-state and next-register logic for the IDLE/REQ/DONE sequence.
   always_comb begin
      state_next = state_reg;
      req_next   = 1'b0;
      we_next    = we_reg;
      addr_next  = addr_reg;
      wdata_next = wdata_reg;
      sel_next   = sel_reg;
      rdata_next = rdata_reg;
      cnt_next   = cnt_reg;
      err_next   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (dmem.mem_ce_i) begin
               if (dmem.mem_we_i && (dmem.mem_sel_i == 4'b0000)) begin
                  // store with no lanes enabled: nothing to put on the bus
                  rdata_next = '0;
                  state_next = DONE;
               end else begin
                  we_next    = dmem.mem_we_i;
                  addr_next  = dmem.mem_addr_i;
                  wdata_next = dmem.mem_data_i;
                  // a read with no lanes selected fetches the whole word
                  sel_next   = (dmem.mem_sel_i == 4'b0000) ? 4'b1111 : dmem.mem_sel_i;
                  cnt_next   = '0;
                  req_next   = 1'b1;
                  state_next = REQ;
               end
            end
         end

         REQ: begin
            if (dmem.bus_ack_i) begin
               // ack beats a simultaneous timeout
               rdata_next = we_reg ? 32'h0 : dmem.bus_rdata_i;
               cnt_next   = '0;
               state_next = DONE;
            end else if (cnt_reg == CNT_LAST) begin
               rdata_next = '0;
               cnt_next   = '0;
               err_next   = 1'b1;
               state_next = DONE;
            end else begin
               cnt_next   = cnt_reg + CNT_W'(1);
               req_next   = 1'b1;
            end
         end

         DONE: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Pipeline-facing outputs: stall while a request waits or runs, data only in DONE.
   always_comb begin
      dmem.stall_req_o = ((state_reg == IDLE) && dmem.mem_ce_i) || (state_reg == REQ);
      dmem.mem_data_o  = (state_reg == DONE) ? rdata_reg : 32'h0;
   end

   assign dmem.bus_req_o   = req_reg;
   assign dmem.bus_we_o    = we_reg;
   assign dmem.bus_addr_o  = addr_reg;
   assign dmem.bus_wdata_o = wdata_reg;
   assign dmem.bus_sel_o   = sel_reg;
   assign dmem.bus_err_o   = err_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with TIMEOUT = 4.
module tb_dmem_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   dmem_ctrl_if dif ();

   dmem_ctrl #(
      .TIMEOUT (4),
      .CNT_W   (8)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .dmem (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
      end
   endtask

   // advance past the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // let combinational outputs settle after driving inputs
   task automatic settle();
      #1;
   endtask

   task automatic drive(input logic ce, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] sel);
      dif.mem_ce_i   = ce;
      dif.mem_we_i   = we;
      dif.mem_addr_i = addr;
      dif.mem_data_i = data;
      dif.mem_sel_i  = sel;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      dif.bus_ack_i   = 1'b0;
      dif.bus_rdata_i = 32'h0;

      // ---------------- reset ----------------
      tick();
      tick();
      rst = 1'b0;
      settle();
      chk1 ("rst_stall", dif.stall_req_o, 1'b0);
      chk1 ("rst_req",   dif.bus_req_o,   1'b0);
      chk1 ("rst_we",    dif.bus_we_o,    1'b0);
      chk32("rst_addr",  dif.bus_addr_o,  32'h0);
      chk32("rst_wdata", dif.bus_wdata_o, 32'h0);
      chk32("rst_sel",   {28'h0, dif.bus_sel_o}, 32'h0);
      chk1 ("rst_err",   dif.bus_err_o,   1'b0);
      chk32("rst_mdata", dif.mem_data_o,  32'h0);
      $display("txn reset: outputs idle");

      // ---------------- LW, immediate ack ----------------
      drive(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'b1111);
      settle();
      chk1 ("lw_idle_stall", dif.stall_req_o, 1'b1);
      chk1 ("lw_idle_req",   dif.bus_req_o,   1'b0);
      tick();
      chk1 ("lw_req",        dif.bus_req_o,   1'b1);
      chk1 ("lw_we",         dif.bus_we_o,    1'b0);
      chk32("lw_addr",       dif.bus_addr_o,  32'h0000_0010);
      chk32("lw_sel",        {28'h0, dif.bus_sel_o}, 32'hF);
      chk1 ("lw_req_stall",  dif.stall_req_o, 1'b1);
      chk32("lw_req_mdata",  dif.mem_data_o,  32'h0);
      dif.bus_ack_i   = 1'b1;
      dif.bus_rdata_i = 32'hDEAD_BEEF;
      tick();
      dif.bus_ack_i   = 1'b0;
      dif.bus_rdata_i = 32'h0;
      settle();
      chk1 ("lw_done_stall", dif.stall_req_o, 1'b0);
      chk1 ("lw_done_req",   dif.bus_req_o,   1'b0);
      chk32("lw_done_mdata", dif.mem_data_o,  32'hDEAD_BEEF);
      chk1 ("lw_done_err",   dif.bus_err_o,   1'b0);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      chk32("lw_idle_mdata", dif.mem_data_o,  32'h0);
      chk1 ("lw_idle2_stall", dif.stall_req_o, 1'b0);
      $display("txn LW addr=00000010 data=%h", 32'hDEAD_BEEF);

      // ---------------- SB, 3 wait states ----------------
      drive(1'b1, 1'b1, 32'h0000_0013, 32'hABAB_ABAB, 4'b0001);
      settle();
      chk1 ("sb_idle_stall", dif.stall_req_o, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk1 ($sformatf("sb_req%0d", i),   dif.bus_req_o,   1'b1);
         chk1 ($sformatf("sb_stall%0d", i), dif.stall_req_o, 1'b1);
         if (i == 4) begin
            dif.bus_ack_i   = 1'b1;
            dif.bus_rdata_i = 32'h1234_5678;
         end
      end
      chk1 ("sb_we",    dif.bus_we_o,    1'b1);
      chk32("sb_sel",   {28'h0, dif.bus_sel_o}, 32'h1);
      chk32("sb_addr",  dif.bus_addr_o,  32'h0000_0013);
      chk32("sb_wdata", dif.bus_wdata_o, 32'hABAB_ABAB);
      tick();
      dif.bus_ack_i   = 1'b0;
      dif.bus_rdata_i = 32'h0;
      settle();
      chk1 ("sb_done_stall", dif.stall_req_o, 1'b0);
      chk1 ("sb_done_req",   dif.bus_req_o,   1'b0);
      chk32("sb_done_mdata", dif.mem_data_o,  32'h0);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      $display("txn SB addr=00000013 sel=0001");

      // ---------------- read timeout ----------------
      drive(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'b1111);
      settle();
      chk1 ("to_idle_stall", dif.stall_req_o, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk1 ($sformatf("to_req%0d", i), dif.bus_req_o, 1'b1);
         chk1 ($sformatf("to_err%0d", i), dif.bus_err_o, 1'b0);
      end
      tick();
      chk1 ("to_done_err",   dif.bus_err_o,   1'b1);
      chk1 ("to_done_req",   dif.bus_req_o,   1'b0);
      chk1 ("to_done_stall", dif.stall_req_o, 1'b0);
      chk32("to_done_mdata", dif.mem_data_o,  32'h0);
      // a late ack in DONE must be ignored
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      dif.bus_ack_i   = 1'b1;
      dif.bus_rdata_i = 32'h5555_5555;
      tick();
      dif.bus_ack_i   = 1'b0;
      dif.bus_rdata_i = 32'h0;
      settle();
      chk1 ("to_err_clear",  dif.bus_err_o,   1'b0);
      chk1 ("to_idle_req",   dif.bus_req_o,   1'b0);
      chk1 ("to_idle_stall", dif.stall_req_o, 1'b0);
      $display("txn LW addr=00000020 timeout");

      // ---------------- write with sel = 0000 ----------------
      drive(1'b1, 1'b1, 32'h0000_0030, 32'h7777_7777, 4'b0000);
      settle();
      chk1 ("w0_idle_stall", dif.stall_req_o, 1'b1);
      tick();
      chk1 ("w0_done_req",   dif.bus_req_o,   1'b0);
      chk1 ("w0_done_stall", dif.stall_req_o, 1'b0);
      chk32("w0_done_mdata", dif.mem_data_o,  32'h0);
      chk32("w0_addr_hold",  dif.bus_addr_o,  32'h0000_0020);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      chk1 ("w0_idle_req",   dif.bus_req_o,   1'b0);
      $display("txn SW addr=00000030 sel=0000 (no bus)");

      // ---------------- read with sel = 0000 -> full word ----------------
      drive(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'b0000);
      tick();
      chk1 ("r0_req",  dif.bus_req_o, 1'b1);
      chk32("r0_sel",  {28'h0, dif.bus_sel_o}, 32'hF);
      chk32("r0_addr", dif.bus_addr_o, 32'h0000_0040);
      dif.bus_ack_i   = 1'b1;
      dif.bus_rdata_i = 32'h0BAD_F00D;
      tick();
      dif.bus_ack_i   = 1'b0;
      chk32("r0_mdata", dif.mem_data_o, 32'h0BAD_F00D);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      $display("txn LW addr=00000040 sel=0000 data=%h", 32'h0BAD_F00D);

      // ---------------- ack coinciding with timeout ----------------
      drive(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'b1100);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk1 ($sformatf("at_req%0d", i), dif.bus_req_o, 1'b1);
      end
      dif.bus_ack_i   = 1'b1;
      dif.bus_rdata_i = 32'hCAFE_0001;
      tick();
      dif.bus_ack_i   = 1'b0;
      chk1 ("at_err",   dif.bus_err_o,  1'b0);
      chk32("at_mdata", dif.mem_data_o, 32'hCAFE_0001);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      $display("txn LW addr=00000044 ack on last wait cycle");

      // ---------------- reset mid-REQ ----------------
      drive(1'b1, 1'b0, 32'h0000_0050, 32'h0, 4'b1111);
      tick();
      chk1 ("mr_req1", dif.bus_req_o, 1'b1);
      tick();
      chk1 ("mr_req2", dif.bus_req_o, 1'b1);
      rst = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      rst = 1'b0;
      dif.bus_ack_i   = 1'b1;
      dif.bus_rdata_i = 32'hFFFF_FFFF;
      settle();
      chk1 ("mr_req",   dif.bus_req_o,   1'b0);
      chk1 ("mr_stall", dif.stall_req_o, 1'b0);
      chk32("mr_addr",  dif.bus_addr_o,  32'h0);
      tick();
      dif.bus_ack_i   = 1'b0;
      dif.bus_rdata_i = 32'h0;
      settle();
      chk1 ("mr_req_after",  dif.bus_req_o,  1'b0);
      chk32("mr_mdata",      dif.mem_data_o, 32'h0);
      chk1 ("mr_err",        dif.bus_err_o,  1'b0);
      $display("txn reset during REQ: ack ignored");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
